port_rd_frontend: RTL and testbench
===================================

PORT_RD_FRONTEND -- requirements
Module: port_rd_frontend

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one packet word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, staging FIFO entries (power of two, >=4).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-high reset (1 = reset asserted).
REQ-005 SHALL have port xfer_data_vld  input  1  upstream word valid this cycle.
REQ-006 SHALL have port xfer_data  input  DATA_WIDTH  upstream packet word.
REQ-007 SHALL have port xfer_end_of_packet  input  1  qualifies xfer_data as last word of packet.
REQ-008 SHALL have port xfer_ready  output  1  FIFO can accept a word this cycle.
REQ-009 SHALL have port ready  input  1  egress port can accept a new packet.
REQ-010 SHALL have port rd_sop  output  1  one-cycle start-of-packet pulse.
REQ-011 SHALL have port rd_vld  output  1  rd_data valid.
REQ-012 SHALL have port rd_data  output  DATA_WIDTH  packet word.
REQ-013 SHALL have port rd_eop  output  1  one-cycle end-of-packet pulse.
REQ-014 SHALL have port overflow  output  1  sticky flag: word offered while FIFO full.

Function
REQ-015 SHALL store {xfer_end_of_packet, xfer_data} in FIFO when xfer_data_vld=1 and FIFO not full.
REQ-016 SHALL drive xfer_ready = (fifo_count < FIFO_DEPTH), from registered count only, ignoring same-cycle pop.
REQ-017 SHALL drop word and set overflow when xfer_data_vld=1 while full; overflow clears only on reset.
REQ-018 SHALL implement FSM states IDLE, SOP, DATA, EOP; reset state IDLE.
REQ-019 IDLE: if ready=1 and FIFO non-empty -> SOP; else stay; ready ignored in all other states.
REQ-020 SOP: rd_sop=1 for exactly this cycle; next state DATA unconditionally.
REQ-021 DATA: if FIFO non-empty, pop one word, next cycle rd_vld=1 and rd_data=word; if empty, rd_vld=0 next cycle (gap), stay DATA.
REQ-022 DATA: popping word with end flag set -> EOP; rd_vld for that word coincides with first EOP cycle.
REQ-023 EOP: rd_eop=1 in cycle after last rd_vld; then IDLE.
REQ-024 Latency: ready=1 with non-empty FIFO in IDLE at cycle c -> rd_sop at c+1, first rd_vld at c+2 earliest; back-to-back packets separated by >=1 idle cycle after rd_eop.
REQ-025 Push and pop in same cycle SHALL both occur; count unchanged; at full, push still refused (REQ-016).
REQ-026 rd_sop, rd_vld, rd_eop never asserted simultaneously; rd_data holds last value when rd_vld=0.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-028 Single-word packet SHALL produce rd_sop, one rd_vld, rd_eop in three consecutive cycles when data available.

Reset
REQ-029 While rst_n=1: FSM->IDLE, FIFO emptied, rd_sop/rd_vld/rd_eop/overflow=0, rd_data=0, xfer_ready=1 after release.
REQ-030 Reset mid-packet SHALL abort packet with no rd_eop; words in FIFO discarded.

Structure
REQ-031 Package hydra_pkg SHALL hold DATA_WIDTH default and rd_state_t enum (IDLE, SOP, DATA, EOP).
REQ-032 FIFO SHALL be sub-module port_rd_fifo (sync, first-word registered read, count output); FSM and output registers in port_rd_frontend.

Verification
REQ-033 Push 4 words (last flagged) with ready=1 -> rd_sop, 4 consecutive rd_vld with same data order, rd_eop next cycle.
REQ-034 ready=0 with 3 words queued for 10 cycles -> no rd_sop; raise ready -> rd_sop next cycle.
REQ-035 Upstream feeds 1 word every 3 cycles in DATA -> rd_vld gaps of 2 cycles, no rd_eop until flagged word.
REQ-036 Push 9 words with no pop, FIFO_DEPTH=8 -> xfer_ready=0 after 8th, 9th dropped, overflow=1 sticky.
REQ-037 rst_n=1 for 1 cycle after 2nd rd_vld of 5-word packet -> all outputs 0, no rd_eop, FIFO empty.
REQ-038 Two 1-word packets queued, ready held 1 -> sop,vld,eop,idle,sop,vld,eop.

Source files
------------

// File: rtl/hydra_pkg.sv
// Shared definitions for the port read front end.
//   DATA_WIDTH_DFLT : default packet word width
//   rd_state_t      : read-side packet FSM states
package hydra_pkg;

    localparam int unsigned DATA_WIDTH_DFLT = 16;

    typedef enum logic [1:0] {
        IDLE,
        SOP,
        DATA,
        EOP
    } rd_state_t;

endpackage

// File: rtl/port_rd_fifo.sv
// Synchronous staging FIFO. The storage array is registered and the head entry is
// presented directly, so a popped word is available in the same cycle as the pop.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_push, i_wdata       : write strobe and entry (ignored while full)
//   i_pop                 : read strobe (ignored while empty)
//   o_rdata               : current head entry
//   o_count               : number of stored entries
module port_rd_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && (r_count != CNT_FULL);
    assign w_do_pop  = i_pop && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/port_rd_frontend.sv
// Port read front end: stages upstream packet words in a FIFO and replays each packet to
// the egress port framed by one-cycle rd_sop / rd_eop pulses.
// Ports:
//   clk, rst_n             : clock, synchronous active-high reset (1 = reset)
//   xfer_data_vld/_data    : upstream word and valid
//   xfer_end_of_packet     : marks the last word of a packet
//   xfer_ready             : FIFO has room (from registered count)
//   ready                  : egress can take a new packet
//   rd_sop/rd_vld/rd_eop   : registered framing and data-valid strobes
//   rd_data                : packet word, held while rd_vld is low
//   overflow               : sticky, a word was offered while the FIFO was full
module port_rd_frontend
    import hydra_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  xfer_data_vld,
    input  logic [DATA_WIDTH-1:0] xfer_data,
    input  logic                  xfer_end_of_packet,
    output logic                  xfer_ready,
    input  logic                  ready,
    output logic                  rd_sop,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_eop,
    output logic                  overflow
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = FIFO_DEPTH[CW-1:0];

    logic [CW-1:0]         w_count;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sop_nxt;
    logic                  w_eop_nxt;
    rd_state_t             w_state_nxt;

    rd_state_t             r_state;
    logic                  r_rd_sop;
    logic                  r_rd_vld;
    logic                  r_rd_eop;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_overflow;

    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == CNT_FULL);
    assign w_push  = xfer_data_vld && !w_full;

    port_rd_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst_n),
        .i_push  (w_push),
        .i_wdata ({xfer_end_of_packet, xfer_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // SOP already pops the first word so its rd_vld lands right after rd_sop; a one-word
    // packet therefore leaves SOP straight for EOP. EOP spans two cycles: the last rd_vld,
    // then the rd_eop cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_sop_nxt   = 1'b0;
        w_eop_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (ready && !w_empty) begin
                    w_state_nxt = SOP;
                    w_sop_nxt   = 1'b1;
                end
            end
            SOP, DATA: begin
                w_state_nxt = DATA;
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head[DATA_WIDTH]) begin
                        w_state_nxt = EOP;
                    end
                end
            end
            EOP: begin
                w_eop_nxt = r_rd_vld;
                if (!r_rd_vld) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= IDLE;
            r_rd_sop   <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_rd_eop   <= 1'b0;
            r_rd_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_sop <= w_sop_nxt;
            r_rd_vld <= w_pop;
            r_rd_eop <= w_eop_nxt;
            if (w_pop) begin
                r_rd_data <= w_head[DATA_WIDTH-1:0];
            end
            if (xfer_data_vld && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign xfer_ready = !w_full;
    assign rd_sop     = r_rd_sop;
    assign rd_vld     = r_rd_vld;
    assign rd_eop     = r_rd_eop;
    assign rd_data    = r_rd_data;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_port_rd_frontend.sv
// Self-checking bench for port_rd_frontend: a queue-based packet model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_port_rd_frontend;

    localparam int DW = 16;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          xfer_data_vld;
    logic [DW-1:0] xfer_data;
    logic          xfer_end_of_packet;
    logic          xfer_ready;
    logic          ready;
    logic          rd_sop;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          rd_eop;
    logic          overflow;

    always #5 clk = ~clk;

    port_rd_frontend #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (D)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .xfer_data_vld      (xfer_data_vld),
        .xfer_data          (xfer_data),
        .xfer_end_of_packet (xfer_end_of_packet),
        .xfer_ready         (xfer_ready),
        .ready              (ready),
        .rd_sop             (rd_sop),
        .rd_vld             (rd_vld),
        .rd_data            (rd_data),
        .rd_eop             (rd_eop),
        .overflow           (overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a word queue, a flag for "packet in progress", and a countdown
    // covering the last-word and rd_eop cycles during which no new packet may start.
    logic [DW:0]   mq[$];
    bit            m_stream;
    int            m_tail;
    bit            cmp_en = 1'b0;
    bit            m_start, m_pop, m_push;
    logic [DW:0]   m_w;
    logic          e_sop, e_vld, e_eop, e_ovf, e_xr;
    logic [DW-1:0] e_data;

    always @(posedge clk) begin
        if (rst_n) begin
            mq.delete();
            m_stream = 1'b0;
            m_tail   = 0;
            e_sop = 0; e_vld = 0; e_eop = 0; e_ovf = 0; e_xr = 1; e_data = '0;
            cmp_en   = 1'b1;
        end else begin
            m_start = !m_stream && (m_tail == 0) && ready && (mq.size() > 0);
            m_pop   = m_stream && (mq.size() > 0);
            m_push  = xfer_data_vld && (mq.size() < D);
            if (xfer_data_vld && mq.size() == D) e_ovf = 1'b1;
            e_sop = m_start;
            e_vld = m_pop;
            e_eop = (m_tail == 2);
            if (m_tail != 0) m_tail--;
            if (m_pop) begin
                m_w    = mq.pop_front();
                e_data = m_w[DW-1:0];
                if (m_w[DW]) begin
                    m_stream = 1'b0;
                    m_tail   = 2;
                end
            end
            if (m_push) mq.push_back({xfer_end_of_packet, xfer_data});
            if (m_start) m_stream = 1'b1;
            e_xr = (mq.size() < D);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rd_sop", 32'(rd_sop), 32'(e_sop));
            chk("rd_vld", 32'(rd_vld), 32'(e_vld));
            chk("rd_eop", 32'(rd_eop), 32'(e_eop));
            chk("rd_data", 32'(rd_data), 32'(e_data));
            chk("overflow", 32'(overflow), 32'(e_ovf));
            chk("xfer_ready", 32'(xfer_ready), 32'(e_xr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic last);
        xfer_data_vld      = 1'b1;
        xfer_data          = d;
        xfer_end_of_packet = last;
        tick();
        xfer_data_vld      = 1'b0;
        xfer_end_of_packet = 1'b0;
    endtask

    logic [15:0]   cap_sop, cap_vld, cap_eop;
    logic [DW-1:0] cap_data [16];

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_sop[k]  = rd_sop;
            cap_vld[k]  = rd_vld;
            cap_eop[k]  = rd_eop;
            cap_data[k] = rd_data;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; xfer_data_vld = 1'b0; xfer_data = '0; xfer_end_of_packet = 1'b0;
        ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_sop", 32'(rd_sop), 0);
        chk("reset_vld", 32'(rd_vld), 0);
        chk("reset_eop", 32'(rd_eop), 0);
        chk("reset_data", 32'(rd_data), 0);
        chk("reset_overflow", 32'(overflow), 0);
        chk("reset_xfer_ready", 32'(xfer_ready), 1);
        tick();

        // 4-word packet held back by ready=0, then released.
        begin : t_four_word
            logic seen;
            seen = 1'b0;
            push_word(16'hA001, 1'b0);
            push_word(16'hB002, 1'b0);
            push_word(16'hC003, 1'b0);
            push_word(16'hD004, 1'b1);
            repeat (10) begin
                @(negedge clk);
                seen = seen | rd_sop;
            end
            chk("no_sop_while_not_ready", 32'(seen), 0);
            tick();
            ready = 1'b1;
            capture(8);
            ready = 1'b0;
            chk("four_sop_pattern", 32'(cap_sop[7:0]), 32'h02);
            chk("four_vld_pattern", 32'(cap_vld[7:0]), 32'h3C);
            chk("four_eop_pattern", 32'(cap_eop[7:0]), 32'h40);
            chk("four_data0", 32'(cap_data[2]), 32'hA001);
            chk("four_data1", 32'(cap_data[3]), 32'hB002);
            chk("four_data2", 32'(cap_data[4]), 32'hC003);
            chk("four_data3", 32'(cap_data[5]), 32'hD004);
            tick();
        end

        // Two single-word packets with ready held high.
        push_word(16'h0011, 1'b1);
        push_word(16'h0022, 1'b1);
        ready = 1'b1;
        capture(9);
        ready = 1'b0;
        chk("pair_sop_pattern", 32'(cap_sop[8:0]), 32'h022);
        chk("pair_vld_pattern", 32'(cap_vld[8:0]), 32'h044);
        chk("pair_eop_pattern", 32'(cap_eop[8:0]), 32'h088);
        chk("pair_data0", 32'(cap_data[2]), 32'h0011);
        chk("pair_data1", 32'(cap_data[6]), 32'h0022);
        tick();

        // Fill to depth with no pop, then offer a ninth word.
        for (int i = 0; i < D; i++) push_word(DW'(16'h0100 + i), 1'b0);
        @(negedge clk);
        chk("full_xfer_ready", 32'(xfer_ready), 0);
        chk("full_no_overflow_yet", 32'(overflow), 0);
        tick();
        push_word(16'h0999, 1'b0);
        @(negedge clk);
        chk("overflow_set", 32'(overflow), 1);
        repeat (5) tick();
        @(negedge clk);
        chk("overflow_sticky", 32'(overflow), 1);
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("overflow_cleared_by_reset", 32'(overflow), 0);
        chk("fifo_empty_after_reset", 32'(xfer_ready), 1);
        tick();

        // Reset after the second rd_vld of a 5-word packet.
        begin : t_abort
            int nv;
            int guard;
            logic seen;
            nv = 0; guard = 0; seen = 1'b0;
            for (int i = 0; i < 5; i++) push_word(DW'(16'h0500 + i), i == 4);
            ready = 1'b1;
            while (nv < 2 && guard < 20) begin
                @(negedge clk);
                if (rd_vld) nv++;
                guard++;
            end
            chk("abort_second_vld_seen", nv, 2);
            tick();
            rst_n = 1'b1;
            ready = 1'b0;
            tick();
            rst_n = 1'b0;
            ready = 1'b1;
            @(negedge clk);
            chk("abort_sop", 32'(rd_sop), 0);
            chk("abort_vld", 32'(rd_vld), 0);
            chk("abort_eop", 32'(rd_eop), 0);
            chk("abort_data", 32'(rd_data), 0);
            repeat (6) begin
                @(negedge clk);
                seen = seen | rd_sop | rd_vld | rd_eop;
            end
            chk("abort_fifo_discarded", 32'(seen), 0);
            tick();
        end

        // One word every third cycle while the packet is in progress.
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_word(DW'(16'h0700 + i), i == 2);
            tick();
            tick();
        end
        repeat (4) tick();

        // Randomized traffic in phases of differing input rates.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int div;
            case (cyc / 1000)
                0:       div = 2;
                1:       div = 3;
                2:       div = 1;
                default: div = 4;
            endcase
            rst_n              = ($urandom_range(0, 399) == 0);
            xfer_data_vld      = ($urandom_range(0, div - 1) == 0);
            xfer_data          = DW'($urandom);
            xfer_end_of_packet = ($urandom_range(0, 3) == 0);
            ready              = (cyc / 1000 == 2) ? ($urandom_range(0, 3) == 0)
                                                   : ($urandom_range(0, 3) != 0);
            tick();
        end
        rst_n = 1'b0; xfer_data_vld = 1'b0; ready = 1'b0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
